// File: rtl/dataflow_pkg.sv
// Pipeline-register record types passed between stages.
package dataflow_pkg;
    import extensions_pkg::*;

    typedef logic [31:0] instruction_t;

    typedef struct packed {
        logic [DataSize-1:0] pc;
        logic [DataSize-1:0] pc_plus_4;
        instruction_t        inst;
    } if_id_t;
endpackage

// File: rtl/extensions_pkg.sv
// Core-wide extension parameters shared by the pipeline stages.
package extensions_pkg;
    localparam int unsigned DataSize = 32;
endpackage

// File: rtl/fetch_pkg.sv
// Types and constants local to the instruction-fetch stage.
package fetch_pkg;
    import extensions_pkg::*;
    import dataflow_pkg::*;

    typedef enum logic [1:0] {
        Idle,
        Request,
        Discard
    } fetch_state_t;

    typedef struct packed {
        logic [DataSize-1:0] pc;
        instruction_t        inst;
    } fetch_entry_t;

    localparam logic [DataSize-1:0] PcIncrement = DataSize'(4);
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, inst} entries with flush; flush wins over push/pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            i_flush,
    input  logic            i_push,
    input  fetch_entry_t    i_push_data,
    input  logic            i_pop,
    output fetch_entry_t    o_head,
    output logic [CntW-1:0] o_count,
    output logic            o_full,
    output logic            o_empty
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t    r_mem [DEPTH];
    logic [PtrW-1:0] r_rd_ptr;
    logic [PtrW-1:0] r_wr_ptr;
    logic [CntW-1:0] r_count;
    logic            w_do_push;
    logic            w_do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        o_full    = (r_count == CntW'(DEPTH));
        o_empty   = (r_count == '0);
        w_do_push = i_push && !i_flush && !o_full;
        w_do_pop  = i_pop && !i_flush && !o_empty;
        o_head    = r_mem[r_rd_ptr];
        o_count   = r_count;
    end

    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= r_count + CntW'(w_do_push) - CntW'(w_do_pop);
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: single-outstanding memory requests, buffered responses, redirect flush.
// FETCH_BYPASS_EN: present an ack straight to decode when the buffer is empty and decode is ready.
module fetch_stage
    import extensions_pkg::*;
    import dataflow_pkg::*;
    import fetch_pkg::*;
#(
    parameter logic [DataSize-1:0] RESET_PC   = '0,
    parameter int unsigned         FIFO_DEPTH = 2
) (
    input  logic                clock,
    input  logic                reset,
    output logic                inst_mem_en,
    output logic [DataSize-1:0] inst_mem_addr,
    input  logic                inst_mem_ack,
    input  logic [31:0]         inst_mem_rd_data,
    input  logic                redirect_en,
    input  logic [DataSize-1:0] redirect_pc,
    input  logic                id_ready,
    output logic                if_id_valid,
    output if_id_t              if_id_o
);
    localparam int unsigned         CntW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CntW-1:0]     FullCount = CntW'(FIFO_DEPTH);
    localparam logic [DataSize-1:0] AlignMask = DataSize'(3);

    fetch_state_t        r_state;
    logic [DataSize-1:0] r_fetch_pc;
    logic [DataSize-1:0] r_mem_addr;
    logic                r_mem_en;

    logic                w_ack;
    logic                w_bypass;
    logic                w_push;
    logic                w_pop;
    logic                w_fifo_valid;
    logic                w_hold_addr;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [CntW-1:0]     w_count;
    logic [CntW-1:0]     w_count_next;
    logic [DataSize-1:0] w_redirect_pc;
    logic [DataSize-1:0] w_pc_next;
    fetch_entry_t        w_head;
    fetch_entry_t        w_push_entry;

    always_comb begin
        w_redirect_pc = redirect_pc & ~AlignMask;
        w_ack         = (r_state == Request) && inst_mem_ack;
`ifdef FETCH_BYPASS_EN
        w_bypass      = w_ack && w_fifo_empty && id_ready && !redirect_en;
`else
        w_bypass      = 1'b0;
`endif
        w_push        = w_ack && !redirect_en && !w_bypass;
        w_fifo_valid  = !w_fifo_empty && !redirect_en;
        w_pop         = w_fifo_valid && id_ready;
        w_count_next  = w_count + CntW'(w_push) - CntW'(w_pop);
        w_push_entry  = '{pc: r_fetch_pc, inst: inst_mem_rd_data};

        w_pc_next = r_fetch_pc;
        if (redirect_en) begin
            w_pc_next = w_redirect_pc;
        end else if (w_ack) begin
            w_pc_next = r_fetch_pc + PcIncrement;
        end

        // The abandoned request keeps its address on the bus until memory acks it.
        w_hold_addr = ((r_state == Request) && redirect_en && !inst_mem_ack)
                   || ((r_state == Discard) && !inst_mem_ack);

        if_id_valid = w_fifo_valid || w_bypass;
        if_id_o     = '0;
        if (w_bypass) begin
            if_id_o.pc        = r_fetch_pc;
            if_id_o.pc_plus_4 = r_fetch_pc + PcIncrement;
            if_id_o.inst      = inst_mem_rd_data;
        end else if (!w_fifo_empty) begin
            if_id_o.pc        = w_head.pc;
            if_id_o.pc_plus_4 = w_head.pc + PcIncrement;
            if_id_o.inst      = w_head.inst;
        end

        inst_mem_en   = r_mem_en;
        inst_mem_addr = r_mem_addr;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= Idle;
            r_fetch_pc <= RESET_PC;
            r_mem_en   <= 1'b0;
            r_mem_addr <= RESET_PC;
        end else begin
            r_fetch_pc <= w_pc_next;
            if (!w_hold_addr) begin
                r_mem_addr <= w_pc_next;
            end
            unique case (r_state)
                Idle: begin
                    if (redirect_en || !w_fifo_full) begin
                        r_state  <= Request;
                        r_mem_en <= 1'b1;
                    end
                end
                Request: begin
                    if (redirect_en) begin
                        if (inst_mem_ack) begin
                            r_state  <= Idle;
                            r_mem_en <= 1'b0;
                        end else begin
                            r_state <= Discard;
                        end
                    end else if (inst_mem_ack && !(w_count_next < FullCount)) begin
                        r_state  <= Idle;
                        r_mem_en <= 1'b0;
                    end
                end
                Discard: begin
                    if (inst_mem_ack) begin
                        r_state  <= Idle;
                        r_mem_en <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= Idle;
                    r_mem_en <= 1'b0;
                end
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .i_flush     (redirect_en),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle vector table plus multi-cycle sequences.
`timescale 1ns/1ps
module tb_fetch_stage;
    import extensions_pkg::*;
    import dataflow_pkg::*;

`ifdef FETCH_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif
    localparam logic [31:0] Nil = 32'hDEAD_0BAD;

    logic        clock = 1'b0;
    logic        reset;
    logic        inst_mem_en, inst_mem_ack, redirect_en, id_ready, if_id_valid;
    logic [31:0] inst_mem_addr, inst_mem_rd_data, redirect_pc;
    if_id_t      if_id_o;

    logic        wr_en, wr_ack, wr_valid;
    logic [31:0] wr_addr;
    if_id_t      wr_o;

    always #5 clock = ~clock;

    fetch_stage #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
        .clock(clock), .reset(reset),
        .inst_mem_en(inst_mem_en), .inst_mem_addr(inst_mem_addr),
        .inst_mem_ack(inst_mem_ack), .inst_mem_rd_data(inst_mem_rd_data),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .id_ready(id_ready), .if_id_valid(if_id_valid), .if_id_o(if_id_o)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut_wrap (
        .clock(clock), .reset(reset),
        .inst_mem_en(wr_en), .inst_mem_addr(wr_addr),
        .inst_mem_ack(wr_ack), .inst_mem_rd_data(32'h0000_0013),
        .redirect_en(1'b0), .redirect_pc(32'h0),
        .id_ready(1'b1), .if_id_valid(wr_valid), .if_id_o(wr_o)
    );

    typedef struct {
        logic rst; logic ack; logic [31:0] rdata; logic redir; logic [31:0] rpc; logic rdy;
        logic en; logic [31:0] addr; logic valid; logic [31:0] pc; logic [31:0] pc4; logic [31:0] inst;
    } vec_t;

    vec_t        vecs[$];
    int          total = 0;
    int          bad = 0;
    int          cycle = 0;
    bit          mem_auto = 1'b0;
    logic [31:0] ack_addrs[$], acc_pcs[$], acc_pc4[$], acc_inst[$], wrap_addrs[$];
    int          ack_cyc[$], acc_cyc[$];

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : Nil;
    endfunction

    task automatic add(input logic rst, ack, input logic [31:0] rdata, input logic redir,
                       input logic [31:0] rpc, input logic rdy, input logic en,
                       input logic [31:0] addr, input logic valid,
                       input logic [31:0] pc, pc4, inst);
        vec_t v;
        v = '{rst, ack, rdata, redir, rpc, rdy, en, addr, valid, pc, pc4, inst};
        vecs.push_back(v);
    endtask

    // One clock cycle: drive this cycle's inputs just after the edge, then observe.
    task automatic cyc(input logic rst, ack, input logic [31:0] rdata, input logic redir,
                       input logic [31:0] rpc, input logic rdy);
        @(posedge clock);
        #1;
        cycle++;
        reset = rst; redirect_en = redir; redirect_pc = rpc; id_ready = rdy;
        if (mem_auto) begin
            inst_mem_ack     = inst_mem_en;
            inst_mem_rd_data = 32'h0000_0013 | (inst_mem_addr << 8);
        end else begin
            inst_mem_ack     = ack;
            inst_mem_rd_data = rdata;
        end
        wr_ack = wr_en;
        #1;
        if (inst_mem_en && inst_mem_ack) begin
            ack_addrs.push_back(inst_mem_addr);
            ack_cyc.push_back(cycle);
        end
        if (wr_en && wr_ack) wrap_addrs.push_back(wr_addr);
        if (if_id_valid && id_ready) begin
            acc_pcs.push_back(if_id_o.pc);
            acc_pc4.push_back(if_id_o.pc_plus_4);
            acc_inst.push_back(if_id_o.inst);
            acc_cyc.push_back(cycle);
        end
    endtask

    task automatic clear_logs();
        ack_addrs.delete(); acc_pcs.delete(); acc_pc4.delete(); acc_inst.delete();
        wrap_addrs.delete(); ack_cyc.delete(); acc_cyc.delete();
    endtask

    task automatic do_reset();
        mem_auto = 1'b0;
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        clear_logs();
    endtask

    initial begin
        reset = 1'b0; inst_mem_ack = 1'b0; inst_mem_rd_data = '0;
        redirect_en = 1'b0; redirect_pc = '0; id_ready = 1'b0; wr_ack = 1'b0;

        //   rst ack rdata         redir rpc        rdy | en addr       v  pc         pc4        inst
        add(0, 0, 32'h0,        0, 32'h0,   0,  0, 32'h0,   0, 32'h0,   32'h0,   32'h0);
        add(1, 0, 32'h0,        0, 32'h0,   0,  0, 32'h0,   0, 32'h0,   32'h0,   32'h0);
        add(1, 1, 32'h00000013, 0, 32'h0,   0,  1, 32'h0,   0, 32'h0,   32'h0,   32'h0);
        add(1, 1, 32'h00100093, 0, 32'h0,   0,  1, 32'h4,   1, 32'h0,   32'h4,   32'h00000013);
        add(1, 0, 32'h0,        0, 32'h0,   0,  0, 32'h8,   1, 32'h0,   32'h4,   32'h00000013);
        add(1, 0, 32'h0,        0, 32'h0,   1,  0, 32'h8,   1, 32'h0,   32'h4,   32'h00000013);
        add(1, 0, 32'h0,        0, 32'h0,   0,  0, 32'h8,   1, 32'h4,   32'h8,   32'h00100093);
        add(1, 0, 32'h0,        0, 32'h0,   0,  1, 32'h8,   1, 32'h4,   32'h8,   32'h00100093);
        add(1, 1, 32'h00200113, 0, 32'h0,   1,  1, 32'h8,   1, 32'h4,   32'h8,   32'h00100093);
        add(1, 0, 32'h0,        0, 32'h0,   1,  1, 32'hC,   1, 32'h8,   32'hC,   32'h00200113);
        add(1, 0, 32'h0,        0, 32'h0,   1,  1, 32'hC,   0, 32'h0,   32'h0,   32'h0);
        add(1, 0, 32'h0,        1, 32'h103, 1,  1, 32'hC,   0, 32'h0,   32'h0,   32'h0);
        add(1, 0, 32'h0,        0, 32'h0,   1,  1, 32'hC,   0, 32'h0,   32'h0,   32'h0);
        add(1, 1, 32'hDEADBEEF, 0, 32'h0,   1,  1, 32'hC,   0, 32'h0,   32'h0,   32'h0);
        add(1, 0, 32'h0,        0, 32'h0,   1,  0, 32'h100, 0, 32'h0,   32'h0,   32'h0);
        add(1, 1, 32'h00000013, 0, 32'h0,   0,  1, 32'h100, 0, 32'h0,   32'h0,   32'h0);
        add(1, 0, 32'h0,        0, 32'h0,   0,  1, 32'h104, 1, 32'h100, 32'h104, 32'h00000013);
        add(1, 1, 32'h11111111, 1, 32'h200, 1,  1, 32'h104, 0, 32'h100, 32'h104, 32'h00000013);
        add(1, 0, 32'h0,        0, 32'h0,   1,  0, 32'h200, 0, 32'h0,   32'h0,   32'h0);
        add(1, 0, 32'h0,        0, 32'h0,   1,  1, 32'h200, 0, 32'h0,   32'h0,   32'h0);
        add(0, 1, 32'h55555555, 0, 32'h0,   0,  1, 32'h200, 0, 32'h0,   32'h0,   32'h0);
        add(0, 0, 32'h0,        0, 32'h0,   0,  0, 32'h0,   0, 32'h0,   32'h0,   32'h0);
        add(1, 0, 32'h0,        0, 32'h0,   0,  0, 32'h0,   0, 32'h0,   32'h0,   32'h0);
        add(1, 0, 32'h0,        0, 32'h0,   0,  1, 32'h0,   0, 32'h0,   32'h0,   32'h0);

        do_reset();
        foreach (vecs[i]) begin
            cyc(vecs[i].rst, vecs[i].ack, vecs[i].rdata, vecs[i].redir, vecs[i].rpc, vecs[i].rdy);
            check($sformatf("vec%0d {en,addr,valid,pc,pc4,inst}", i),
                  {inst_mem_en, inst_mem_addr, if_id_valid, if_id_o.pc, if_id_o.pc_plus_4, if_id_o.inst},
                  {vecs[i].en, vecs[i].addr, vecs[i].valid, vecs[i].pc, vecs[i].pc4, vecs[i].inst});
        end

        // Streaming from reset with zero-wait memory and decode always ready.
        do_reset();
        mem_auto = 1'b1;
        for (int i = 0; i < 12; i++) cyc(1, 0, 0, 0, 0, 1);
        check("stream ack addr0", qget(ack_addrs, 0), 32'h0);
        check("stream ack addr1", qget(ack_addrs, 1), 32'h4);
        check("stream ack addr2", qget(ack_addrs, 2), 32'h8);
        check("stream pc0", qget(acc_pcs, 0), 32'h0);
        check("stream pc_plus_4_0", qget(acc_pc4, 0), 32'h4);
        check("stream inst0", qget(acc_inst, 0), 32'h0000_0013);
        check("stream pc1", qget(acc_pcs, 1), 32'h4);
        check("stream pc2", qget(acc_pcs, 2), 32'h8);
        check("stream ack-to-valid latency",
              (ack_cyc.size() > 0 && acc_cyc.size() > 0) ? 32'(acc_cyc[0] - ack_cyc[0]) : Nil,
              Byp ? 32'd0 : 32'd1);
        check("wrap first addr", qget(wrap_addrs, 0), 32'hFFFF_FFFC);
        check("wrap second addr", qget(wrap_addrs, 1), 32'h0);

        // Decode stalled: buffer fills, requests stop, then drains in order.
        do_reset();
        mem_auto = 1'b1;
        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 0, 0);
        check("stall ack count", 32'(ack_addrs.size()), 32'd2);
        check("stall mem_en", {31'd0, inst_mem_en}, 32'd0);
        for (int i = 0; i < 12; i++) cyc(1, 0, 0, 0, 0, 1);
        check("drain pc0", qget(acc_pcs, 0), 32'h0);
        check("drain pc1", qget(acc_pcs, 1), 32'h4);
        check("drain pc2", qget(acc_pcs, 2), 32'h8);

        // Redirect while a slow response is outstanding.
        do_reset();
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        check("slow req {en,addr}", {inst_mem_en, inst_mem_addr}, {1'b1, 32'h0});
        cyc(1, 0, 0, 1, 32'h100, 0);
        cyc(1, 0, 0, 0, 0, 0);
        check("discard holds {en,addr}", {inst_mem_en, inst_mem_addr}, {1'b1, 32'h0});
        cyc(1, 1, 32'hBAD0_0BAD, 0, 0, 1);
        check("discard ack valid", {31'd0, if_id_valid}, 32'd0);
        cyc(1, 0, 0, 0, 0, 1);
        check("after discard {en,valid}", {inst_mem_en, if_id_valid}, 2'b00);
        clear_logs();
        mem_auto = 1'b1;
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, 0, 1);
        check("post-redirect ack addr", qget(ack_addrs, 0), 32'h100);
        check("post-redirect first pc", qget(acc_pcs, 0), 32'h100);
        check("post-redirect first inst", qget(acc_inst, 0), 32'h0001_0013);

        // Ack into an empty buffer with decode ready.
        do_reset();
        cyc(1, 0, 0, 0, 0, 1);
        cyc(1, 1, 32'h0000_0013, 0, 0, 1);
        check("empty ack valid", {31'd0, if_id_valid}, {31'd0, Byp});
        cyc(1, 0, 0, 0, 0, 0);
        check("cycle after empty ack valid", {31'd0, if_id_valid}, {31'd0, !Byp});
        check("cycle after empty ack pc", if_id_o.pc, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
